// File: rtl/sync_up_counter.sv
// Synchronous up counter with programmable terminal count, parallel load,
// synchronous clear, a cascade terminal-count output, a one-cycle wrap pulse
// and a sticky overflow flag.
module sync_up_counter #(
    parameter int WIDTH   = 4,
    parameter int MAX_VAL = 2**WIDTH-1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             carry,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] out_q, out_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             at_top;

    // >= rather than == so an out-of-range count still wraps cleanly.
    assign at_top = (out_q >= MAX);

    // Next state: clr beats load beats en beats hold.
    always_comb begin
        out_d   = out_q;
        carry_d = 1'b0;
        ovf_d   = ovf_q;
        if (clr) begin
            out_d = '0;
            ovf_d = 1'b0;
        end else if (load) begin
            out_d = (din > MAX) ? MAX : din;
        end else if (en) begin
            if (at_top) begin
                out_d   = '0;
                carry_d = 1'b1;
                ovf_d   = 1'b1;
            end else begin
                out_d = out_q + WIDTH'(1);
            end
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            out_q   <= out_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    // tc is unregistered so a downstream stage's enable lines up with this
    // stage's wrap edge.
    assign tc    = en && (out_q == MAX);
    assign out   = out_q;
    assign carry = carry_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_sync_up_counter.sv
// Bench for sync_up_counter: four instances (mod-16, mod-10, a mod-10 stage
// cascaded from the first mod-10, and a mod-2) driven by shared stimulus and
// checked every cycle against an arithmetic model, plus literal spot checks.
module tb_sync_up_counter;

    logic       clk, rst, en, clr, load;
    logic [3:0] din;

    logic [3:0] o15, o9a, o9b;
    logic [1:0] o1;
    logic       tc15, tc9a, tc9b, tc1;
    logic       c15, c9a, c9b, c1;
    logic       v15, v9a, v9b, v1;

    sync_up_counter #(.WIDTH(4), .MAX_VAL(15)) u15 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .din(din),
        .out(o15), .tc(tc15), .carry(c15), .ovf(v15));
    sync_up_counter #(.WIDTH(4), .MAX_VAL(9)) u9a (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .din(din),
        .out(o9a), .tc(tc9a), .carry(c9a), .ovf(v9a));
    sync_up_counter #(.WIDTH(4), .MAX_VAL(9)) u9b (
        .clk(clk), .rst(rst), .en(tc9a), .clr(clr), .load(load), .din(din),
        .out(o9b), .tc(tc9b), .carry(c9b), .ovf(v9b));
    sync_up_counter #(.WIDTH(2), .MAX_VAL(1)) u1 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .din(din[1:0]),
        .out(o1), .tc(tc1), .carry(c1), .ovf(v1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int ncmp = 0;
    int nerr = 0;
    bit run  = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    int mmax[4] = '{15, 9, 9, 1};
    int mw[4]   = '{4, 4, 4, 2};
    int mcnt[4], mcar[4], movf[4];

    function automatic int men(input int i);
        if (i == 2) return (en && mcnt[1] == mmax[1]) ? 1 : 0;
        return en ? 1 : 0;
    endfunction

    always @(posedge clk or negedge rst) begin
        int e[4];
        int lv;
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                mcnt[i] = 0; mcar[i] = 0; movf[i] = 0;
            end
        end else begin
            for (int i = 0; i < 4; i++) e[i] = men(i);
            for (int i = 0; i < 4; i++) begin
                mcar[i] = 0;
                if (clr) begin
                    mcnt[i] = 0; movf[i] = 0;
                end else if (load) begin
                    lv = int'(din) % (1 << mw[i]);
                    mcnt[i] = (lv > mmax[i]) ? mmax[i] : lv;
                end else if (e[i] != 0) begin
                    if (mcnt[i] == mmax[i]) begin
                        mcnt[i] = 0; mcar[i] = 1; movf[i] = 1;
                    end else begin
                        mcnt[i] = mcnt[i] + 1;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [3:0] aout[4];
    logic       atc[4], acar[4], aovf[4];
    assign aout[0] = o15;  assign aout[1] = o9a;  assign aout[2] = o9b;  assign aout[3] = {2'b00, o1};
    assign atc[0]  = tc15; assign atc[1]  = tc9a; assign atc[2]  = tc9b; assign atc[3]  = tc1;
    assign acar[0] = c15;  assign acar[1] = c9a;  assign acar[2] = c9b;  assign acar[3] = c1;
    assign aovf[0] = v15;  assign aovf[1] = v9a;  assign aovf[2] = v9b;  assign aovf[3] = v1;

    always @(negedge clk) begin
        if (run) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("out[%0d]", i), int'(aout[i]), mcnt[i]);
                chk($sformatf("carry[%0d]", i), int'(acar[i]), mcar[i]);
                chk($sformatf("ovf[%0d]", i), int'(aovf[i]), movf[i]);
                chk($sformatf("tc[%0d]", i), int'(atc[i]),
                    (men(i) != 0 && mcnt[i] == mmax[i]) ? 1 : 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called just after a rising edge; applies inputs, returns just after the
    // edge that sampled them.
    task automatic tick(input logic e, input logic c, input logic l, input logic [3:0] d);
        en = e; clr = c; load = l; din = d;
        @(posedge clk);
        #1;
    endtask

    int c1cnt;

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; load = 1'b0; din = '0;
        #1 rst = 1'b0;
        run = 1'b1;
        // inputs ignored during reset; tc stays low
        en = 1'b1; load = 1'b1; din = 4'd9;
        @(posedge clk); #1;
        chk("rst out15", int'(o15), 0);
        chk("rst tc9a", int'(tc9a), 0);
        chk("rst ovf15", int'(v15), 0);
        en = 1'b0; load = 1'b0; din = '0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // free run 17 cycles
        for (int k = 1; k <= 17; k++) begin
            tick(1'b1, 1'b0, 1'b0, 4'd0);
            if (k == 2)  chk("u1 carry k2", int'(c1), 1);
            if (k == 3)  chk("u1 carry k3", int'(c1), 0);
            if (k == 4)  chk("u1 carry k4", int'(c1), 1);
            if (k == 9)  begin chk("u9 out k9", int'(o9a), 9); chk("u9 tc k9", int'(tc9a), 1); end
            if (k == 10) begin chk("u9 out k10", int'(o9a), 0); chk("u9 carry k10", int'(c9a), 1); end
            if (k == 15) begin chk("u15 out k15", int'(o15), 15); chk("u15 tc k15", int'(tc15), 1); chk("u15 carry k15", int'(c15), 0); end
            if (k == 16) begin chk("u15 out k16", int'(o15), 0); chk("u15 carry k16", int'(c15), 1); chk("u15 ovf k16", int'(v15), 1); end
            if (k == 17) begin chk("u15 out k17", int'(o15), 1); chk("u15 carry k17", int'(c15), 0); chk("u15 ovf k17", int'(v15), 1); end
        end

        // clamped load
        tick(1'b0, 1'b0, 1'b1, 4'd12);
        chk("u9 clamp", int'(o9a), 9);
        chk("u15 load12", int'(o15), 12);

        // clr beats load and en; load beats en
        tick(1'b0, 1'b0, 1'b1, 4'd7);
        chk("u15 out=7", int'(o15), 7);
        tick(1'b1, 1'b1, 1'b1, 4'd5);
        chk("clr out", int'(o15), 0);
        chk("clr ovf", int'(v15), 0);
        chk("clr carry", int'(c15), 0);
        tick(1'b1, 1'b0, 1'b1, 4'd5);
        chk("load>en", int'(o15), 5);

        // en toggling from 3
        tick(1'b0, 1'b0, 1'b1, 4'd3);
        tick(1'b1, 1'b0, 1'b0, 4'd0); chk("tog1", int'(o15), 4);
        tick(1'b0, 1'b0, 1'b0, 4'd0); chk("tog2", int'(o15), 4);
        tick(1'b1, 1'b0, 1'b0, 4'd0); chk("tog3", int'(o15), 5); chk("tog3 tc", int'(tc15), 0);
        tick(1'b0, 1'b0, 1'b0, 4'd0); chk("tog4", int'(o15), 5); chk("tog4 carry", int'(c15), 0);

        // async reset mid-cycle at out=11, ovf=1
        tick(1'b0, 1'b0, 1'b1, 4'd15);
        tick(1'b1, 1'b0, 1'b0, 4'd0);
        tick(1'b0, 1'b0, 1'b1, 4'd11);
        chk("pre-rst out", int'(o15), 11);
        chk("pre-rst ovf", int'(v15), 1);
        load = 1'b0;
        #3 rst = 1'b0;
        #1;
        chk("async out", int'(o15), 0);
        chk("async ovf", int'(v15), 0);
        chk("async carry", int'(c15), 0);
        @(posedge clk); #1;
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        tick(1'b1, 1'b0, 1'b0, 4'd0);
        chk("post-rst out", int'(o15), 1);

        // cascaded decade pair, 100 enabled cycles
        tick(1'b0, 1'b1, 1'b0, 4'd0);
        c1cnt = 0;
        for (int k = 1; k <= 100; k++) begin
            tick(1'b1, 1'b0, 1'b0, 4'd0);
            if (c9b) c1cnt++;
            if (k == 99) begin chk("chain s0@99", int'(o9a), 9); chk("chain s1@99", int'(o9b), 9); end
        end
        chk("chain s0@100", int'(o9a), 0);
        chk("chain s1@100", int'(o9b), 0);
        chk("chain s1 carry", int'(c9b), 1);
        chk("chain s1 pulses", c1cnt, 1);

        tick(1'b0, 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        run = 1'b0;
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
